// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolution stage: FSM encoding and datapath width defaults.
package branch_resolve_unit_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int OFF_W_DEF  = 19;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } brs_state_e;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter for branch statistics; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            count <= '0;
        else if (inc && !(&count))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Conditional-branch resolution: latches CON and target, strobes a PC load when taken,
// pulses done, and keeps taken/not-taken statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OFF_W  = OFF_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic              flush,
    input  logic              con_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [OFF_W-1:0]  offset,
    output logic              busy,
    output logic              con_q,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              done,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt
);

    brs_state_e        state, state_d;
    logic              accept, resolve;
    logic [ADDR_W-1:0] target, target_d;

    // Sum wraps modulo 2^ADDR_W by truncation.
    assign target_d = pc_in + {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        resolve = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept  = 1'b1;
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    resolve = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // pc_load and done are launched from the RESOLVE edge so both land in the DONE cycle.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            con_q   <= 1'b0;
            target  <= '0;
            pc_next <= '0;
            pc_load <= 1'b0;
            done    <= 1'b0;
        end else begin
            pc_load <= resolve && con_q;
            done    <= resolve;
            if (accept) begin
                con_q  <= con_in;
                target <= target_d;
            end
            if (resolve && con_q)
                pc_next <= target;
        end
    end

    assign busy = (state != IDLE);

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clock   (clock),
        .clear_n (clear_n),
        .inc     (resolve && con_q),
        .count   (taken_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_not_taken_cnt (
        .clock   (clock),
        .clear_n (clear_n),
        .inc     (resolve && !con_q),
        .count   (not_taken_cnt)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed table, corner sequences and random traffic vs a transaction-level model.
module tb_branch_resolve_unit;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          start = 1'b0, flush = 1'b0, con_in = 1'b0;
    logic [31:0]   pc_in = '0;
    logic [18:0]   offset = '0;
    logic          busy, con_q, pc_load, done;
    logic [31:0]   pc_next;
    logic [CW-1:0] taken_cnt, not_taken_cnt;

    branch_resolve_unit #(.ADDR_W(32), .OFF_W(19), .CNT_W(CW)) dut (
        .clock         (clock),
        .clear_n       (clear_n),
        .start         (start),
        .flush         (flush),
        .con_in        (con_in),
        .pc_in         (pc_in),
        .offset        (offset),
        .busy          (busy),
        .con_q         (con_q),
        .pc_load       (pc_load),
        .pc_next       (pc_next),
        .done          (done),
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Model: age = cycles since the request was accepted (-1 = no request in flight).
    int          age;
    logic        m_con;
    logic [31:0] m_tgt, m_pcn;
    int          m_tc, m_nc;

    function automatic void model_reset();
        age = -1; m_con = 1'b0; m_tgt = '0; m_pcn = '0; m_tc = 0; m_nc = 0;
    endfunction

    function automatic void model_edge();
        longint offv;
        case (age)
            -1: if (start && !flush) begin
                offv  = (offset >= 19'h40000) ? longint'(offset) - (longint'(1) << 19) : longint'(offset);
                m_con = con_in;
                m_tgt = 32'(longint'(pc_in) + offv);
                age   = 0;
            end
            0: if (flush) age = -1;
               else begin
                   age = 1;
                   if (m_con) begin
                       m_pcn = m_tgt;
                       if (m_tc < SAT) m_tc++;
                   end else if (m_nc < SAT) m_nc++;
               end
            default: age = -1;
        endcase
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("busy",          busy,          age != -1);
        chk("con_q",         con_q,         m_con);
        chk("pc_load",       pc_load,       (age == 1) && m_con);
        chk("done",          done,          age == 1);
        chk("pc_next",       pc_next,       m_pcn);
        chk("taken_cnt",     taken_cnt,     m_tc);
        chk("not_taken_cnt", not_taken_cnt, m_nc);
    endtask

    task automatic cycle();
        @(posedge clock);
        if (clear_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        start = 1'b0; flush = 1'b0;
        clear_n = 1'b0;
        model_reset();
        #1;
        check_all();
        cycle();
        cycle();
        clear_n = 1'b1;
    endtask

    task automatic scramble();
        con_in = 1'($urandom); pc_in = $urandom; offset = 19'($urandom);
    endtask

    task automatic run_req(input logic c, input logic [31:0] p, input logic [18:0] o);
        start = 1'b1; con_in = c; pc_in = p; offset = o;
        cycle();
        start = 1'b0; scramble();
        cycle();
        cycle();
    endtask

    typedef struct {
        logic        con;
        logic [31:0] pc;
        logic [18:0] off;
        logic [31:0] exp_pcn;
        logic        exp_load;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int dones;
        tbl[0] = '{1'b1, 32'h0000_0100, 19'h00010, 32'h0000_0110, 1'b1};
        tbl[1] = '{1'b0, 32'h0000_0200, 19'h7FFFF, 32'h0000_0110, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0005, 19'h7FFF8, 32'hFFFF_FFFD, 1'b1};
        tbl[3] = '{1'b1, 32'hFFFF_FFFF, 19'h00001, 32'h0000_0000, 1'b1};
        tbl[4] = '{1'b1, 32'h0000_1000, 19'h3FFFF, 32'h0004_0FFF, 1'b1};
        tbl[5] = '{1'b1, 32'h0000_1000, 19'h40000, 32'hFFFC_1000, 1'b1};

        do_reset();

        // Directed table: fixed expectations checked in the load/done cycle.
        foreach (tbl[i]) begin
            start = 1'b1; con_in = tbl[i].con; pc_in = tbl[i].pc; offset = tbl[i].off;
            cycle();
            start = 1'b0; scramble();
            cycle();
            chk("tbl_pc_next", pc_next, tbl[i].exp_pcn);
            chk("tbl_pc_load", pc_load, tbl[i].exp_load);
            chk("tbl_done",    done,    1'b1);
            cycle();
            chk("tbl_idle",    busy,    1'b0);
        end
        chk("tbl_taken",     taken_cnt,     5);
        chk("tbl_not_taken", not_taken_cnt, 1);

        // Flush during RESOLVE: no load, no done, counters untouched.
        start = 1'b1; con_in = 1'b1; pc_in = 32'h300; offset = 19'h4;
        cycle();
        start = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_done", done, 1'b0);
        chk("flush_taken", taken_cnt, 5);
        cycle();
        chk("flush_no_load", pc_load, 1'b0);

        // start together with flush in IDLE is ignored.
        start = 1'b1; flush = 1'b1;
        cycle();
        start = 1'b0; flush = 1'b0;
        chk("start_flush_ignored", busy, 1'b0);

        // start held 6 cycles resolves exactly two requests.
        dones = 0;
        start = 1'b1; con_in = 1'b0; pc_in = 32'h400; offset = 19'h8;
        for (int k = 0; k < 6; k++) begin cycle(); if (done) dones++; end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin cycle(); if (done) dones++; end
        chk("held_start_requests", dones, 2);

        // Async reset mid-RESOLVE.
        start = 1'b1; con_in = 1'b1; pc_in = 32'h40; offset = 19'h4;
        cycle();
        start = 1'b0;
        #1 clear_n = 1'b0;
        model_reset();
        #1;
        chk("arst_busy",    busy,    1'b0);
        chk("arst_con_q",   con_q,   1'b0);
        chk("arst_pc_next", pc_next, 0);
        chk("arst_taken",   taken_cnt, 0);
        #1 clear_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 3; k++) begin cycle(); if (done || pc_load) dones++; end
        chk("arst_no_pulse", dones, 0);
        run_req(1'b1, 32'h1000, 19'h20);
        chk("arst_resume_pc", pc_next, 32'h1020);

        // Saturation of the taken counter.
        do_reset();
        for (int k = 0; k < (1 << CW) + 3; k++) run_req(1'b1, $urandom, 19'($urandom));
        chk("sat_taken", taken_cnt, SAT);
        run_req(1'b1, 32'h0, 19'h1);
        chk("sat_hold", taken_cnt, SAT);
        chk("sat_not_taken", not_taken_cnt, 0);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            start  = ($urandom_range(0, 2) != 0);
            flush  = ($urandom_range(0, 9) == 0);
            scramble();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
